mux_arbiter: RTL and testbench
==============================

// Module: mux_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for the 2:1 WIDTH-bit multiplexer datapath.
//   Two requesters offer data with valid/ready handshakes. The block picks one,
//   drives the mux Selector, and registers the selected word into a one-entry
//   output buffer with its own valid/ready handshake. It also keeps per-source
//   saturating grant counters, for display on Basys3 LEDs/7-seg.
// PARAMETERS
//   WIDTH           4  data width of each source and of DataOut
//   CNT_WIDTH       8  width of each grant counter
//   FIXED_PRIORITY  0  1 = source 0 always wins ties; 0 = round-robin
// PORTS
//   Clock      in   1          single clock, all state on rising edge
//   Reset      in   1          synchronous, active-high
//   In0        in   WIDTH      source 0 data
//   Req0       in   1          source 0 valid
//   Ack0       out  1          source 0 ready; transfer when Req0 && Ack0
//   In1        in   WIDTH      source 1 data
//   Req1       in   1          source 1 valid
//   Ack1       out  1          source 1 ready; transfer when Req1 && Ack1
//   DataOut    out  WIDTH      registered selected word
//   OutValid   out  1          DataOut holds an unconsumed word
//   OutReady   in   1          consumer ready; word consumed when OutValid && OutReady
//   Selector   out  1          registered; source of the word in DataOut (0/1)
//   Count0     out  CNT_WIDTH  number of grants to source 0, saturating
//   Count1     out  CNT_WIDTH  number of grants to source 1, saturating
// BEHAVIOUR
//   - Reset (sync, mid-operation included):
//       state=IDLE, DataOut=0, OutValid=0, Selector=0, Count0=Count1=0,
//       LastGrant=1 (source 0 wins the first tie). Any in-flight word is dropped.
//   - Load = !OutValid || OutReady (buffer empty, or being drained this cycle).
//   - Pick (combinational):
//       only Req0 -> 0; only Req1 -> 1; both -> !LastGrant
//       (FIXED_PRIORITY=1: both -> 0); neither -> none.
//   - Ack0 = Load && pick==0 && Req0; Ack1 likewise.
//       Acks are combinational, at most one high, and never high during Reset.
//   - Requester rule: hold InX stable while ReqX && !AckX. Req may drop without Ack.
//   - On a transfer: next edge sets DataOut=InX, Selector=X, OutValid=1,
//     LastGrant=X, and CountX+1 saturating at 2^CNT_WIDTH-1.
//     Latency is 1 cycle from Ack to OutValid.
//   - Load with no request and OutReady: OutValid->0; DataOut/Selector keep last value.
//   - Simultaneous drain + new grant: back-to-back, OutValid stays 1,
//     giving 1 word/cycle throughput.
//   - OutValid && !OutReady: DataOut, Selector, OutValid held; both Acks 0 (stall).
//   - FSM: IDLE (OutValid=0), HOLD0, HOLD1 (OutValid=1, Selector=0/1).
//       IDLE -grant X-> HOLDX.
//       HOLDX -Load & grant Y-> HOLDY.
//       HOLDX -Load & no grant-> IDLE.
//       HOLDX -!Load-> HOLDX.
//       Illegal state code -> IDLE.
// STRUCTURE
//   - Shared package/header mux_pkg: state encodings
//     ST_IDLE=2'b00, ST_HOLD0=2'b01, ST_HOLD1=2'b10.
//   - Sub-module rr_pick_2: combinational picker
//     (Req0, Req1, LastGrant, FIXED_PRIORITY -> GrantValid, GrantIdx).
//   - The existing 4-bit Multiplexer is instantiated for the data path,
//     driven by GrantIdx.
// TESTING
//   - Reset: assert Reset 2 cycles with Req0=Req1=1 -> Ack0=Ack1=0, OutValid=0,
//     DataOut=0, Counts=0.
//   - Single source: Req0=1 In0=4'hA, OutReady=1 -> Ack0 same cycle; next cycle
//     DataOut=A, Selector=0, OutValid=1, Count0=1.
//   - Contention, RR: Req0=Req1=1 (In0=3, In1=C), OutReady=1 for 4 cycles ->
//     DataOut sequence 3,C,3,C; Selector 0,1,0,1; Count0=Count1=2.
//   - Backpressure: OutValid=1, OutReady=0 for 5 cycles with both Req high ->
//     Acks 0, DataOut stable; OutReady=1 -> next grant loads the same cycle.
//   - Saturation: CNT_WIDTH=2, 5 grants to source 1 -> Count1 sticks at 3.
//   - Mid-op reset: Reset during HOLD1 with Req1 high -> next cycle IDLE,
//     OutValid=0, Counts=0; first tie afterwards is granted to source 0.
//   - Bench ends with "All test cases pass" or "Some test cases fail", then $finish.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 mux arbiter: FSM state encodings and a small helper.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD0 = 2'b01,
    ST_HOLD1 = 2'b10
  } state_t;

  function automatic state_t hold_state(input logic idx);
    return idx ? ST_HOLD1 : ST_HOLD0;
  endfunction

endpackage

// File: rtl/Multiplexer.sv
// Plain 2:1 WIDTH-bit data multiplexer used as the arbiter datapath.
module Multiplexer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] In0,
  input  logic [WIDTH-1:0] In1,
  input  logic             Selector,
  output logic [WIDTH-1:0] Out
);

  always_comb begin
    Out = Selector ? In1 : In0;
  end

endmodule

// File: rtl/rr_pick_2.sv
// Two-way combinational picker: round-robin on ties unless fixed priority is selected.
module rr_pick_2 #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic Req0,
  input  logic Req1,
  input  logic LastGrant,
  output logic GrantValid,
  output logic GrantIdx
);

  always_comb begin
    GrantValid = Req0 || Req1;
    GrantIdx   = 1'b0;
    if (Req0 && Req1) begin
      GrantIdx = FIXED_PRIORITY ? 1'b0 : !LastGrant;
    end else if (Req1) begin
      GrantIdx = 1'b1;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter/sequencer feeding a one-entry registered output buffer,
// with saturating per-source grant counters.
module mux_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WIDTH-1:0]     In0,
  input  logic                 Req0,
  output logic                 Ack0,
  input  logic [WIDTH-1:0]     In1,
  input  logic                 Req1,
  output logic                 Ack1,
  output logic [WIDTH-1:0]     DataOut,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 Selector,
  output logic [CNT_WIDTH-1:0] Count0,
  output logic [CNT_WIDTH-1:0] Count1
);

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_data;
  logic                 r_sel;
  logic                 r_last;
  logic [CNT_WIDTH-1:0] r_cnt0;
  logic [CNT_WIDTH-1:0] r_cnt1;

  logic                 w_gvalid;
  logic                 w_gidx;
  logic                 w_load;
  logic                 w_legal;
  logic                 w_xfer;
  logic [WIDTH-1:0]     w_mux;

  rr_pick_2 #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_pick (
    .Req0      (Req0),
    .Req1      (Req1),
    .LastGrant (r_last),
    .GrantValid(w_gvalid),
    .GrantIdx  (w_gidx)
  );

  Multiplexer #(
    .WIDTH(WIDTH)
  ) u_mux (
    .In0     (In0),
    .In1     (In1),
    .Selector(w_gidx),
    .Out     (w_mux)
  );

  // An illegal state code blocks grants so no word is accepted and then lost on recovery.
  always_comb begin
    w_legal = (r_state == ST_IDLE) || (r_state == ST_HOLD0) || (r_state == ST_HOLD1);
    w_load  = !OutValid || OutReady;
    w_xfer  = !Reset && w_legal && w_load && w_gvalid;
    Ack0    = w_xfer && !w_gidx && Req0;
    Ack1    = w_xfer &&  w_gidx && Req1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) w_next = hold_state(w_gidx);
      end
      ST_HOLD0, ST_HOLD1: begin
        if (w_load) w_next = w_xfer ? hold_state(w_gidx) : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_data <= w_mux;
        r_sel  <= w_gidx;
        r_last <= w_gidx;
        if (!w_gidx && r_cnt0 != '1) r_cnt0 <= r_cnt0 + 1'b1;
        if ( w_gidx && r_cnt1 != '1) r_cnt1 <= r_cnt1 + 1'b1;
      end
    end
  end

  always_comb begin
    OutValid = (r_state == ST_HOLD0) || (r_state == ST_HOLD1);
    DataOut  = r_data;
    Selector = r_sel;
    Count0   = r_cnt0;
    Count1   = r_cnt1;
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: directed vectors push expected words, a monitor checks them on consumption.
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] In0 = '0, In1 = '0;
  logic       Req0 = 1'b0, Req1 = 1'b0, OutReady = 1'b0;
  logic       Ack0, Ack1, OutValid, Selector;
  logic [3:0] DataOut;
  logic [1:0] Count0, Count1;

  typedef struct packed {
    logic [3:0] d;
    logic       s;
    logic [1:0] c0;
    logic [1:0] c1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux_arbiter #(
    .WIDTH(4),
    .CNT_WIDTH(2),
    .FIXED_PRIORITY(1'b0)
  ) dut (
    .Clock(clk), .Reset(Reset),
    .In0(In0), .Req0(Req0), .Ack0(Ack0),
    .In1(In1), .Req1(Req1), .Ack1(Ack1),
    .DataOut(DataOut), .OutValid(OutValid), .OutReady(OutReady),
    .Selector(Selector), .Count0(Count0), .Count1(Count1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic s, input logic [1:0] c0, input logic [1:0] c1);
    exp_t e;
    e.d = d; e.s = s; e.c0 = c0; e.c1 = c1;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 unit after the edge; combinational checks happen 3 units later.
  task automatic step(input logic r, input logic rq0, input logic rq1,
                      input logic [3:0] d0, input logic [3:0] d1, input logic rdy);
    @(posedge clk);
    #1;
    Reset = r; Req0 = rq0; Req1 = rq1; In0 = d0; In1 = d1; OutReady = rdy;
    #3;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!Reset && OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_word: got data %0h sel %0d, expected no word", DataOut, Selector);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data",   32'(DataOut),  32'(e.d));
        chk("sb_sel",    32'(Selector), 32'(e.s));
        chk("sb_count0", 32'(Count0),   32'(e.c0));
        chk("sb_count1", 32'(Count1),   32'(e.c1));
      end
    end
  end

  logic [3:0] rr_d[4]  = '{4'h3, 4'hC, 4'h3, 4'hC};
  logic       rr_s[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] rr_c0[4] = '{2'd1, 2'd1, 2'd2, 2'd2};
  logic [1:0] rr_c1[4] = '{2'd0, 2'd1, 2'd1, 2'd2};
  logic [1:0] sat_c[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    // Reset held two cycles with both requests up
    step(1'b1, 1'b1, 1'b1, 4'h5, 4'h6, 1'b1);
    chk("rst_ack0", 32'(Ack0), 0);
    chk("rst_ack1", 32'(Ack1), 0);
    step(1'b1, 1'b1, 1'b1, 4'h5, 4'h6, 1'b1);
    chk("rst_ack0b", 32'(Ack0), 0);
    chk("rst_ack1b", 32'(Ack1), 0);
    chk("rst_valid", 32'(OutValid), 0);
    chk("rst_data", 32'(DataOut), 0);
    chk("rst_sel", 32'(Selector), 0);
    chk("rst_cnt0", 32'(Count0), 0);
    chk("rst_cnt1", 32'(Count1), 0);

    // Single source
    step(1'b0, 1'b1, 1'b0, 4'hA, 4'h0, 1'b1);
    chk("single_ack0", 32'(Ack0), 1);
    chk("single_ack1", 32'(Ack1), 0);
    push(4'hA, 1'b0, 2'd1, 2'd0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    chk("single_valid", 32'(OutValid), 1);
    chk("single_data", 32'(DataOut), 32'hA);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    chk("single_drained", 32'(OutValid), 0);
    chk("single_data_kept", 32'(DataOut), 32'hA);

    // Round-robin contention
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'h3, 4'hC, 1'b1);
      chk("rr_ack0", 32'(Ack0), 32'(!rr_s[i]));
      chk("rr_ack1", 32'(Ack1), 32'(rr_s[i]));
      push(rr_d[i], rr_s[i], rr_c0[i], rr_c1[i]);
    end
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    chk("rr_cnt0", 32'(Count0), 2);
    chk("rr_cnt1", 32'(Count1), 2);

    // Backpressure
    do_reset();
    step(1'b0, 1'b1, 1'b1, 4'h5, 4'h6, 1'b1);
    chk("bp_first_ack0", 32'(Ack0), 1);
    push(4'h5, 1'b0, 2'd1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'h5, 4'h6, 1'b0);
      chk("bp_ack0", 32'(Ack0), 0);
      chk("bp_ack1", 32'(Ack1), 0);
      chk("bp_data", 32'(DataOut), 32'h5);
      chk("bp_valid", 32'(OutValid), 1);
    end
    step(1'b0, 1'b1, 1'b1, 4'h5, 4'h6, 1'b1);
    chk("bp_release_ack1", 32'(Ack1), 1);
    chk("bp_release_ack0", 32'(Ack0), 0);
    push(4'h6, 1'b1, 2'd1, 2'd1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'h0, 4'(i + 1), 1'b1);
      chk("sat_ack1", 32'(Ack1), 1);
      push(4'(i + 1), 1'b1, 2'd0, sat_c[i]);
    end
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    chk("sat_cnt1", 32'(Count1), 3);

    // Reset while holding a word from source 1; the word is dropped
    do_reset();
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h9, 1'b0);
    chk("mid_ack1", 32'(Ack1), 1);
    step(1'b0, 1'b0, 1'b1, 4'h0, 4'h9, 1'b0);
    chk("mid_hold_valid", 32'(OutValid), 1);
    chk("mid_hold_sel", 32'(Selector), 1);
    chk("mid_stall_ack1", 32'(Ack1), 0);
    step(1'b1, 1'b0, 1'b1, 4'h0, 4'h9, 1'b0);
    chk("mid_rst_ack1", 32'(Ack1), 0);
    step(1'b0, 1'b1, 1'b1, 4'h7, 4'h8, 1'b1);
    chk("mid_valid", 32'(OutValid), 0);
    chk("mid_cnt0", 32'(Count0), 0);
    chk("mid_cnt1", 32'(Count1), 0);
    chk("mid_tie_ack0", 32'(Ack0), 1);
    chk("mid_tie_ack1", 32'(Ack1), 0);
    push(4'h7, 1'b0, 2'd1, 2'd0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1);
    chk("sb_all_consumed", 32'(exp_q.size()), 0);

    if (n_fail == 0) $display("All test cases pass");
    else             $display("Some test cases fail");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
